mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the pipelined core's instruction-fetch port and its data port.
- Replaces the separate imem/dmem pair when the core targets a unified memory.
- Registered FSM: grants one requester, issues one memory transaction, and returns a one-cycle ready pulse with captured read data.
- A per-transaction timeout watchdog guarantees forward progress.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one variable-latency memory port.
// Optional `ARB_FAIR_EN: after MAX_STREAK data grants while fetch is waiting, fetch wins.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned TIMEOUT    = 15,
   parameter int unsigned MAX_STREAK = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ready_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [3:0]        d_amp_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_ready_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              m_req_o,
   output logic              m_we_o,
   output logic [3:0]        m_amp_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   input  logic              m_ack_i,
   input  logic [DATA_W-1:0] m_rdata_i,
   output logic              err_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   // Counter value in the last ISSUE cycle before the watchdog fires.
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
   localparam logic [7:0] MaxStreak   = 8'(MAX_STREAK);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;  // 1 = data port owns the transaction
   logic              we_q, we_d;
   logic [3:0]        amp_q, amp_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              err_q, err_d;
   logic              pick_data;

`ifdef ARB_FAIR_EN
   logic [7:0] streak_q, streak_d;

   assign pick_data = d_req_i && !(if_req_i && (streak_q == MaxStreak));

   always_comb begin
      streak_d = streak_q;
      if (state_q == StIdle && (if_req_i || d_req_i)) begin
         streak_d = (pick_data && if_req_i) ? streak_q + 8'd1 : 8'd0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) streak_q <= 8'd0;
      else         streak_q <= streak_d;
   end
`else
   logic unused_max_streak;

   assign unused_max_streak = ^MaxStreak;
   assign pick_data         = d_req_i;
`endif

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      amp_d      = amp_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      err_d      = err_q;
      unique case (state_q)
         StIdle: begin
            if (if_req_i || d_req_i) begin
               owner_d = pick_data;
               cnt_d   = 8'd0;
               state_d = StIssue;
               if (pick_data) begin
                  we_d    = d_we_i;
                  amp_d   = d_amp_i;
                  addr_d  = d_addr_i;
                  wdata_d = d_wdata_i;
               end else begin
                  we_d    = 1'b0;
                  amp_d   = 4'hF;
                  addr_d  = if_addr_i;
                  wdata_d = '0;
               end
            end
         end
         StIssue: begin
            // An ack in the watchdog's final cycle still wins.
            if (m_ack_i) begin
               if (owner_q) d_rdata_d  = m_rdata_i;
               else         if_rdata_d = m_rdata_i;
               state_d = StResp;
            end else if (cnt_q == TimeoutLast) begin
               if (owner_q) d_rdata_d  = '0;
               else         if_rdata_d = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         amp_q      <= 4'h0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= 8'd0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         amp_q      <= amp_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         err_q      <= err_d;
      end
   end

   assign m_req_o    = (state_q == StIssue);
   assign m_we_o     = m_req_o & we_q;
   assign m_amp_o    = m_req_o ? amp_q : 4'h0;
   assign m_addr_o   = m_req_o ? addr_q : '0;
   assign m_wdata_o  = m_req_o ? wdata_q : '0;
   assign if_ready_o = (state_q == StResp) && !owner_q;
   assign d_ready_o  = (state_q == StResp) && owner_q;
   assign if_rdata_o = if_rdata_q;
   assign d_rdata_o  = d_rdata_q;
   assign err_o      = err_q;
   assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder with programmable ack
// delay, a ready monitor popping expected transactions, and directed stimulus.
module tb_mem_port_arbiter;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_we, m_ack;
   logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
   logic [3:0]  d_amp;
   logic        if_ready, d_ready, m_req, m_we, err, busy;
   logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
   logic [3:0]  m_amp;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .MAX_STREAK(3)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_amp_i(d_amp), .d_addr_i(d_addr),
      .d_wdata_i(d_wdata), .d_ready_o(d_ready), .d_rdata_o(d_rdata),
      .m_req_o(m_req), .m_we_o(m_we), .m_amp_o(m_amp), .m_addr_o(m_addr),
      .m_wdata_o(m_wdata), .m_ack_i(m_ack), .m_rdata_i(m_rdata),
      .err_o(err), .busy_o(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_data;
      logic        we;
      logic [3:0]  amp;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          cycles;
   } item_t;

   item_t       sb[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          ack_delay = 0;  // ack in ISSUE cycle ack_delay+1; negative = never
   bit          spurious = 1'b0;
   int          issue_len = 0;
   bit          exp_err = 1'b0;
   logic [31:0] exp_if_rd = '0;
   logic [31:0] exp_d_rd = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      if (a == 32'h40) return 32'h0050_0093;
      return (a * 32'h0101_0101) ^ 32'h1234_5678;
   endfunction

   task automatic expect_txn(input bit is_data, input logic we, input logic [3:0] amp,
                             input logic [31:0] addr, input logic [31:0] wd);
      item_t it;
      it.is_data = is_data;
      it.we      = we;
      it.amp     = amp;
      it.addr    = addr;
      it.wdata   = wd;
      if (ack_delay < 0) begin
         exp_err   = 1'b1;
         it.rdata  = '0;
         it.cycles = TMO;
      end else begin
         it.rdata  = rd_model(addr);
         it.cycles = ack_delay + 1;
      end
      it.err = exp_err;
      sb.push_back(it);
   endtask

   // Memory responder; also checks the bus against the in-flight transaction.
   initial begin : responder
      int k;
      k       = 0;
      m_ack   = 1'b0;
      m_rdata = '0;
      forever begin
         @(negedge clk);
         if (m_req) begin
            k++;
            issue_len = k;
            if (sb.size() == 0) begin
               check_eq("m_req_unexpected", 32'(m_req), 32'd0);
            end else begin
               check_eq("m_addr", m_addr, sb[0].addr);
               check_eq("m_we", 32'(m_we), 32'(sb[0].we));
               check_eq("m_amp", 32'(m_amp), 32'(sb[0].amp));
               if (sb[0].is_data) check_eq("m_wdata", m_wdata, sb[0].wdata);
            end
            if (ack_delay >= 0 && k - 1 == ack_delay) begin
               m_ack   = 1'b1;
               m_rdata = rd_model(m_addr);
            end else begin
               m_ack   = 1'b0;
               m_rdata = $urandom;
            end
         end else begin
            k       = 0;
            m_ack   = spurious;
            m_rdata = $urandom;
         end
      end
   end

   initial begin : monitor
      item_t it;
      forever begin
         @(negedge clk);
         if (if_ready || d_ready) begin
            if (if_ready && d_ready) check_eq("both_ready", 32'd1, 32'd0);
            if (sb.size() == 0) begin
               check_eq("ready_unexpected", {30'd0, if_ready, d_ready}, 32'd0);
            end else begin
               it = sb.pop_front();
               check_eq("owner", 32'(d_ready), 32'(it.is_data));
               if (it.is_data) begin
                  exp_d_rd = it.rdata;
                  check_eq("d_rdata", d_rdata, exp_d_rd);
                  check_eq("if_rdata_hold", if_rdata, exp_if_rd);
               end else begin
                  exp_if_rd = it.rdata;
                  check_eq("if_rdata", if_rdata, exp_if_rd);
                  check_eq("d_rdata_hold", d_rdata, exp_d_rd);
               end
               check_eq("err", 32'(err), 32'(it.err));
               check_eq("issue_cycles", 32'(issue_len), 32'(it.cycles));
               check_eq("busy_resp", 32'(busy), 32'd1);
            end
         end
      end
   end

   // Raises the requested ports; data stays up for n_d grants, fetch for one.
   task automatic run(input bit do_f, input logic [31:0] fa, input int n_d, input logic we,
                      input logic [3:0] amp, input logic [31:0] da, input logic [31:0] wd);
      int got_d;
      int cyc;
      got_d = 0;
      cyc   = 0;
      @(negedge clk);
      if (do_f) begin
         if_req  = 1'b1;
         if_addr = fa;
      end
      if (n_d > 0) begin
         d_req   = 1'b1;
         d_we    = we;
         d_amp   = amp;
         d_addr  = da;
         d_wdata = wd;
      end
      while ((if_req || d_req) && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (if_ready) if_req = 1'b0;
         if (d_ready) begin
            got_d++;
            if (got_d == n_d) d_req = 1'b0;
         end
      end
      if (if_req || d_req) begin
         check_eq("wait_budget", 32'd0, 32'd1);
         if_req = 1'b0;
         d_req  = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      item_t it;
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_amp = 4'h0; d_addr = '0; d_wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_m_req", 32'(m_req), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
      check_eq("rst_if_rdata", if_rdata, 32'd0);
      check_eq("rst_d_rdata", d_rdata, 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;

      // Abandon an in-flight load with reset.
      ack_delay  = -1;
      it.is_data = 1'b1; it.we = 1'b0; it.amp = 4'hF; it.addr = 32'h100;
      it.wdata   = '0; it.rdata = '0; it.err = 1'b0; it.cycles = 0;
      sb.push_back(it);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_amp = 4'hF; d_addr = 32'h100; d_wdata = '0;
      repeat (4) @(negedge clk);
      check_eq("pre_rst_m_req", 32'(m_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_m_req", 32'(m_req), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_d_ready", 32'(d_ready), 32'd0);
      d_req = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("post_rst_d_ready", 32'(d_ready), 32'd0);
      check_eq("post_rst_err", 32'(err), 32'd0);
      check_eq("post_rst_d_rdata", d_rdata, 32'd0);

      ack_delay = 0;
      expect_txn(1'b0, 1'b0, 4'hF, 32'h0, '0);
      run(1'b1, 32'h0, 0, 1'b0, 4'h0, '0, '0);

      ack_delay = 2;
      expect_txn(1'b0, 1'b0, 4'hF, 32'h40, '0);
      run(1'b1, 32'h40, 0, 1'b0, 4'h0, '0, '0);

      ack_delay = 1;
      spurious  = 1'b1;
      expect_txn(1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
      run(1'b0, '0, 1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
      repeat (3) @(negedge clk);
      check_eq("spurious_idle_busy", 32'(busy), 32'd0);
      spurious = 1'b0;

      ack_delay = 0;
      expect_txn(1'b1, 1'b0, 4'h0, 32'h300, 32'h55);
      run(1'b0, '0, 1, 1'b0, 4'h0, 32'h300, 32'h55);

      expect_txn(1'b1, 1'b0, 4'hF, 32'h80, '0);
      expect_txn(1'b0, 1'b0, 4'hF, 32'h44, '0);
      run(1'b1, 32'h44, 1, 1'b0, 4'hF, 32'h80, '0);

      ack_delay = 1;
      for (int i = 0; i < 3; i++) expect_txn(1'b1, 1'b0, 4'hF, 32'h180, '0);
`ifdef ARB_FAIR_EN
      expect_txn(1'b0, 1'b0, 4'hF, 32'h48, '0);
      expect_txn(1'b1, 1'b0, 4'hF, 32'h180, '0);
`else
      expect_txn(1'b1, 1'b0, 4'hF, 32'h180, '0);
      expect_txn(1'b0, 1'b0, 4'hF, 32'h48, '0);
`endif
      run(1'b1, 32'h48, 4, 1'b0, 4'hF, 32'h180, '0);

      ack_delay = TMO - 1;
      expect_txn(1'b0, 1'b0, 4'hF, 32'h60, '0);
      run(1'b1, 32'h60, 0, 1'b0, 4'h0, '0, '0);
      check_eq("boundary_err", 32'(err), 32'd0);

      ack_delay = -1;
      expect_txn(1'b1, 1'b0, 4'hF, 32'h400, '0);
      run(1'b0, '0, 1, 1'b0, 4'hF, 32'h400, '0);

      ack_delay = 3;
      expect_txn(1'b0, 1'b0, 4'hF, 32'h64, '0);
      run(1'b1, 32'h64, 0, 1'b0, 4'h0, '0, '0);
      ack_delay = 0;
      expect_txn(1'b1, 1'b1, 4'hC, 32'h204, 32'h1234_ABCD);
      run(1'b0, '0, 1, 1'b1, 4'hC, 32'h204, 32'h1234_ABCD);
      check_eq("err_sticky", 32'(err), 32'd1);
      check_eq("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
